// File: rtl/sw_ctrl.sv
// Control block for the Smith-Waterman accelerator: parameter capture, T-load sequencing,
// calculation sequencing with per-batch max reduction, cycle count and sticky errors.
module sw_ctrl #(
   parameter int SCORE_W = 16,
   parameter int MATCH_W = 4,
   parameter int T_LEN_W = 10,
   parameter int CYC_W   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_set_t,
   input  logic               i_start_cal,
   input  logic               i_abort,
   input  logic               i_param_valid,
   input  logic [MATCH_W-1:0] i_match,
   input  logic [MATCH_W-1:0] i_mismatch,
   input  logic [7:0]         i_minus_alpha,
   input  logic [7:0]         i_minus_beta,
   output logic [SCORE_W-1:0] o_match,
   output logic [SCORE_W-1:0] o_mismatch,
   output logic [SCORE_W-1:0] o_alpha,
   output logic [SCORE_W-1:0] o_beta,
   output logic               o_start_read_t,
   input  logic               i_t_valid,
   input  logic               i_t_last,
   output logic [T_LEN_W-1:0] o_t_size,
   input  logic               i_sram_busy,
   output logic               o_start_cal,
   input  logic               i_pe_busy,
   input  logic [SCORE_W-1:0] i_pe_result,
   input  logic               i_pe_result_valid,
   output logic               o_flush,
   output logic               o_busy,
   output logic [SCORE_W-1:0] o_result,
   output logic               o_valid,
   output logic [CYC_W-1:0]   o_cycles,
   input  logic               i_err_clr,
   output logic [2:0]         o_err
);

   typedef enum logic [1:0] {IDLE, SETT, CALC, FLUSH} state_t;

   localparam logic [T_LEN_W-1:0] T_MAX   = '1;
   localparam logic [T_LEN_W-1:0] T_LAST  = T_MAX - 1'b1;
   localparam logic [CYC_W-1:0]   CYC_MAX = '1;

   state_t             state, state_nx;
   logic               t_loaded, p_loaded;
   logic               t_done;      // last beat seen, waiting for SRAM to go idle
   logic               busy_seen;   // PE busy observed high during this CALC
   logic [T_LEN_W-1:0] t_cnt;
   logic [SCORE_W-1:0] max_r, max_nx;
   logic [CYC_W-1:0]   cyc_cnt, cyc_inc;
   logic               cmd;
   logic               go_sett, go_calc, t_fin, t_ovf, calc_done, abort_sett;
   logic [2:0]         err_set;

   assign cmd     = i_set_t | i_start_cal;
   assign o_busy  = (state != IDLE);
   assign o_flush = (state == FLUSH);
   assign cyc_inc = (cyc_cnt == CYC_MAX) ? cyc_cnt : cyc_cnt + 1'b1;
   assign max_nx  = (i_pe_result_valid && (i_pe_result > max_r)) ? i_pe_result : max_r;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      go_sett    = 1'b0;
      go_calc    = 1'b0;
      t_fin      = 1'b0;
      t_ovf      = 1'b0;
      calc_done  = 1'b0;
      abort_sett = 1'b0;
      err_set    = 3'b000;
      case (state)
         IDLE: begin
            if (i_set_t) begin
               state_nx = SETT;
               go_sett  = 1'b1;
            end else if (i_start_cal) begin
               if (t_loaded && p_loaded) begin
                  state_nx = CALC;
                  go_calc  = 1'b1;
               end else begin
                  err_set[0] = 1'b1;
               end
            end
         end
         SETT: begin
            err_set[2] = cmd;
            if (i_abort) begin
               state_nx   = FLUSH;
               abort_sett = 1'b1;
            end else if (t_done) begin
               if (!i_sram_busy) state_nx = IDLE;
            end else if (i_t_valid && i_t_last) begin
               t_fin = 1'b1;
               if (!i_sram_busy) state_nx = IDLE;
            end else if (i_t_valid && (t_cnt == T_LAST)) begin
               t_ovf      = 1'b1;
               err_set[1] = 1'b1;
               state_nx   = FLUSH;
            end
         end
         CALC: begin
            err_set[2] = cmd;
            if (i_abort) begin
               state_nx = FLUSH;
            end else if (busy_seen && !i_pe_busy) begin
               calc_done = 1'b1;
               state_nx  = IDLE;
            end
         end
         FLUSH: begin
            err_set[2] = cmd;
            if (!i_sram_busy && !i_pe_busy) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Parameters are only accepted while idle so the datapath never sees them change mid-run.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_match    <= '0;
         o_mismatch <= '0;
         o_alpha    <= '0;
         o_beta     <= '0;
         p_loaded   <= 1'b0;
      end else if (state == IDLE && i_param_valid) begin
         o_match    <= SCORE_W'(i_match);
         o_mismatch <= SCORE_W'(i_mismatch);
         o_alpha    <= SCORE_W'(i_minus_alpha);
         o_beta     <= SCORE_W'(i_minus_beta);
         p_loaded   <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         t_cnt    <= '0;
         t_loaded <= 1'b0;
         t_done   <= 1'b0;
         o_t_size <= '0;
      end else if (go_sett) begin
         t_cnt    <= '0;
         t_loaded <= 1'b0;
         t_done   <= 1'b0;
      end else if (state == SETT) begin
         if (abort_sett) begin
            t_loaded <= 1'b0;
         end else if (t_fin) begin
            o_t_size <= t_cnt + 1'b1;
            t_cnt    <= t_cnt + 1'b1;
            t_loaded <= 1'b1;
            t_done   <= 1'b1;
         end else if (t_ovf) begin
            o_t_size <= T_MAX;
            t_cnt    <= T_MAX;
            t_loaded <= 1'b0;
         end else if (i_t_valid && !t_done) begin
            t_cnt <= t_cnt + 1'b1;
         end
      end
   end

   // A result strobe coincident with the busy fall is folded in via max_nx.
   always_ff @(posedge clk) begin
      if (rst) begin
         max_r          <= '0;
         cyc_cnt        <= '0;
         busy_seen      <= 1'b0;
         o_result       <= '0;
         o_cycles       <= '0;
         o_valid        <= 1'b0;
         o_start_read_t <= 1'b0;
         o_start_cal    <= 1'b0;
      end else begin
         o_start_read_t <= go_sett;
         o_start_cal    <= go_calc;
         o_valid        <= calc_done;
         if (go_calc) begin
            max_r     <= '0;
            cyc_cnt   <= '0;
            busy_seen <= 1'b0;
         end else if (state == CALC) begin
            max_r   <= max_nx;
            cyc_cnt <= cyc_inc;
            if (i_pe_busy) busy_seen <= 1'b1;
         end
         if (calc_done) begin
            o_result <= max_nx;
            o_cycles <= cyc_inc;
         end
      end
   end

   // A new error in the same cycle as a clear survives the clear.
   always_ff @(posedge clk) begin
      if (rst)            o_err <= 3'b000;
      else if (i_err_clr) o_err <= err_set;
      else                o_err <= o_err | err_set;
   end

endmodule

// File: tb/tb_sw_ctrl.sv
// Bench for sw_ctrl: parameter table, hand-written multi-cycle sequences and randomized
// T-load / calculation runs checked against a max-of-results / cycle-length model.
module tb_sw_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_set_t, i_start_cal, i_abort, i_param_valid;
   logic [3:0]  i_match, i_mismatch;
   logic [7:0]  i_minus_alpha, i_minus_beta;
   logic [15:0] o_match, o_mismatch, o_alpha, o_beta;
   logic        o_start_read_t, i_t_valid, i_t_last;
   logic [2:0]  o_t_size;
   logic        i_sram_busy, o_start_cal, i_pe_busy;
   logic [15:0] i_pe_result;
   logic        i_pe_result_valid, o_flush, o_busy;
   logic [15:0] o_result;
   logic        o_valid;
   logic [31:0] o_cycles;
   logic        i_err_clr;
   logic [2:0]  o_err;

   sw_ctrl #(.SCORE_W(16), .MATCH_W(4), .T_LEN_W(3), .CYC_W(32)) dut (
      .clk(clk), .rst(rst),
      .i_set_t(i_set_t), .i_start_cal(i_start_cal), .i_abort(i_abort),
      .i_param_valid(i_param_valid), .i_match(i_match), .i_mismatch(i_mismatch),
      .i_minus_alpha(i_minus_alpha), .i_minus_beta(i_minus_beta),
      .o_match(o_match), .o_mismatch(o_mismatch), .o_alpha(o_alpha), .o_beta(o_beta),
      .o_start_read_t(o_start_read_t), .i_t_valid(i_t_valid), .i_t_last(i_t_last),
      .o_t_size(o_t_size), .i_sram_busy(i_sram_busy), .o_start_cal(o_start_cal),
      .i_pe_busy(i_pe_busy), .i_pe_result(i_pe_result), .i_pe_result_valid(i_pe_result_valid),
      .o_flush(o_flush), .o_busy(o_busy), .o_result(o_result), .o_valid(o_valid),
      .o_cycles(o_cycles), .i_err_clr(i_err_clr), .o_err(o_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  m, mm;
      logic [7:0]  a, b;
      logic [15:0] em, emm, ea, eb;
   } pvec_t;

   pvec_t pv[4];
   int    total = 0;
   int    bad   = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic apply_params(input logic [3:0] m, input logic [3:0] mm,
                               input logic [7:0] a, input logic [7:0] b);
      i_param_valid = 1'b1; i_match = m; i_mismatch = mm; i_minus_alpha = a; i_minus_beta = b;
      step();
      i_param_valid = 1'b0;
   endtask

   // T load of len beats; SRAM stays busy for hold cycles after the last beat.
   task automatic load_t(input int len, input int hold);
      i_set_t = 1'b1;
      step();
      i_set_t = 1'b0;
      chk("ld_read_pulse", o_start_read_t, 1);
      for (int k = 1; k <= len; k++) begin
         if ($urandom_range(0, 2) == 0) begin
            i_t_valid = 1'b0;
            step();
         end
         i_t_valid   = 1'b1;
         i_t_last    = (k == len);
         i_sram_busy = (k < len) || (hold > 0);
         step();
      end
      i_t_valid = 1'b0;
      i_t_last  = 1'b0;
      if (hold > 0) begin
         for (int k = 1; k < hold; k++) step();
         chk("ld_wait_sram", o_busy, 1);
         i_sram_busy = 1'b0;
         step();
      end
      chk("ld_idle", o_busy, 0);
      chk("ld_size", o_t_size, len);
   endtask

   // Busy low for d cycles, high for b cycles, then falls; random result strobes throughout.
   task automatic calc_run(input int d, input int b);
      int          mx;
      logic        early;
      logic [15:0] r;
      mx = 0;
      early = 1'b0;
      i_start_cal = 1'b1;
      step();
      i_start_cal = 1'b0;
      chk("rnd_start_pulse", o_start_cal, 1);
      for (int j = 0; j <= d + b; j++) begin
         if (o_valid) early = 1'b1;
         i_pe_busy         = (j >= d) && (j < d + b);
         i_pe_result_valid = 1'($urandom_range(0, 1));
         r                 = 16'($urandom);
         i_pe_result       = r;
         if (i_pe_result_valid && (int'(r) > mx)) mx = int'(r);
         step();
      end
      i_pe_result_valid = 1'b0;
      chk("rnd_no_early_valid", early, 0);
      chk("rnd_valid", o_valid, 1);
      chk("rnd_result", o_result, mx);
      chk("rnd_cycles", o_cycles, d + b + 1);
      chk("rnd_idle", o_busy, 0);
   endtask

   initial begin
      logic seen_valid;
      logic [3:0] rm, rmm;
      logic [7:0] ra, rb;

      pv[0] = '{4'd15, 4'd15, 8'd255, 8'd255, 16'd15, 16'd15, 16'd255, 16'd255};
      pv[1] = '{4'd0,  4'd0,  8'd0,   8'd0,   16'd0,  16'd0,  16'd0,   16'd0};
      pv[2] = '{4'd8,  4'd3,  8'd128, 8'd7,   16'd8,  16'd3,  16'd128, 16'd7};
      pv[3] = '{4'd2,  4'd1,  8'd3,   8'd1,   16'd2,  16'd1,  16'd3,   16'd1};

      rst = 1'b1;
      {i_set_t, i_start_cal, i_abort, i_param_valid, i_t_valid, i_t_last} = '0;
      {i_sram_busy, i_pe_busy, i_pe_result_valid, i_err_clr} = '0;
      i_match = '0; i_mismatch = '0; i_minus_alpha = '0; i_minus_beta = '0; i_pe_result = '0;
      step(); step();
      rst = 1'b0;
      chk("rst_busy", o_busy, 0);
      chk("rst_err", o_err, 0);
      chk("rst_outs", {o_match, o_t_size, o_result, o_cycles, o_valid, o_flush}, 0);

      for (int i = 0; i < 4; i++) begin
         apply_params(pv[i].m, pv[i].mm, pv[i].a, pv[i].b);
         chk("tbl_match", o_match, pv[i].em);
         chk("tbl_mismatch", o_mismatch, pv[i].emm);
         chk("tbl_alpha", o_alpha, pv[i].ea);
         chk("tbl_beta", o_beta, pv[i].eb);
      end

      // start before any T load
      i_start_cal = 1'b1; step(); i_start_cal = 1'b0;
      chk("noT_err", o_err, 3'b001);
      chk("noT_no_start", o_start_cal, 0);
      chk("noT_idle", o_busy, 0);
      i_err_clr = 1'b1; step(); i_err_clr = 1'b0;
      chk("err_clr", o_err, 0);

      load_t(5, 0);
      chk("load5_err", o_err, 0);

      // calc: busy high 20 cycles, results 7, 12, and 9 on the fall cycle
      i_start_cal = 1'b1; step(); i_start_cal = 1'b0;
      chk("calc_start_pulse", o_start_cal, 1);
      chk("calc_busy", o_busy, 1);
      seen_valid = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         i_pe_busy         = 1'b1;
         i_pe_result_valid = (k == 3) || (k == 10);
         i_pe_result       = (k == 3) ? 16'd7 : 16'd12;
         i_param_valid     = (k == 5);
         i_match           = 4'd9;
         step();
         if (o_valid) seen_valid = 1'b1;
      end
      i_param_valid = 1'b0;
      i_pe_busy = 1'b0; i_pe_result_valid = 1'b1; i_pe_result = 16'd9;
      step();
      i_pe_result_valid = 1'b0;
      chk("calc_no_early_valid", seen_valid, 0);
      chk("calc_valid", o_valid, 1);
      chk("calc_result", o_result, 12);
      chk("calc_cycles", o_cycles, 21);
      chk("calc_idle", o_busy, 0);
      chk("calc_param_locked", o_match, 2);
      step();
      chk("calc_valid_pulse", o_valid, 0);

      // abort mid-CALC, set_t during FLUSH
      i_start_cal = 1'b1; step(); i_start_cal = 1'b0;
      i_pe_busy = 1'b1; step(); step();
      i_abort = 1'b1; step(); i_abort = 1'b0;
      chk("abort_flush", o_flush, 1);
      seen_valid = o_valid;
      for (int k = 1; k <= 4; k++) begin
         i_set_t = (k == 2);
         step();
         chk("abort_flush_hold", o_flush, 1);
         if (o_valid || o_start_read_t) seen_valid = 1'b1;
      end
      i_set_t = 1'b0;
      i_pe_busy = 1'b0; step();
      chk("abort_idle", {o_flush, o_busy}, 0);
      chk("abort_no_valid", seen_valid, 0);
      chk("abort_err2", o_err, 3'b100);
      i_err_clr = 1'b1; step(); i_err_clr = 1'b0;

      // T stays loaded across a CALC abort
      i_start_cal = 1'b1; step(); i_start_cal = 1'b0;
      chk("kept_t_start", o_start_cal, 1);
      i_abort = 1'b1; step(); i_abort = 1'b0;
      step();
      chk("kept_t_idle", o_busy, 0);

      // set_t and start_cal together: load wins
      i_set_t = 1'b1; i_start_cal = 1'b1; step(); i_set_t = 1'b0; i_start_cal = 1'b0;
      chk("both_read", o_start_read_t, 1);
      chk("both_no_cal", o_start_cal, 0);
      i_t_valid = 1'b1; i_t_last = 1'b1; step(); i_t_valid = 1'b0; i_t_last = 1'b0;
      chk("both_size1", o_t_size, 1);
      chk("both_idle", o_busy, 0);

      // overflow: 7 beats without last at T_LEN_W=3
      i_set_t = 1'b1; step(); i_set_t = 1'b0;
      i_sram_busy = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         i_t_valid = 1'b1; step();
      end
      i_t_valid = 1'b0;
      chk("ovf_err", o_err, 3'b010);
      chk("ovf_flush", o_flush, 1);
      chk("ovf_size", o_t_size, 7);
      i_sram_busy = 1'b0; step();
      chk("ovf_idle", o_busy, 0);
      i_start_cal = 1'b1; step(); i_start_cal = 1'b0;
      chk("ovf_start_err", o_err, 3'b011);
      chk("ovf_no_start", o_start_cal, 0);
      i_start_cal = 1'b1; i_err_clr = 1'b1; step(); i_start_cal = 1'b0; i_err_clr = 1'b0;
      chk("set_beats_clr", o_err, 3'b001);
      i_err_clr = 1'b1; step(); i_err_clr = 1'b0;

      // reset in the middle of a calculation
      load_t(3, 1);
      i_start_cal = 1'b1; step(); i_start_cal = 1'b0;
      i_pe_busy = 1'b1; step(); step();
      rst = 1'b1; step(); rst = 1'b0; i_pe_busy = 1'b0;
      chk("midrst_state", {o_busy, o_flush, o_valid}, 0);
      chk("midrst_outs", {o_match, o_t_size, o_result, o_cycles}, 0);
      i_start_cal = 1'b1; step(); i_start_cal = 1'b0;
      chk("midrst_start_err", o_err, 3'b001);
      i_err_clr = 1'b1; step(); i_err_clr = 1'b0;

      // randomized loads and calculations
      rm = 4'($urandom); rmm = 4'($urandom); ra = 8'($urandom); rb = 8'($urandom);
      apply_params(rm, rmm, ra, rb);
      chk("rnd_params", {o_match, o_mismatch, o_alpha, o_beta},
          {16'(rm), 16'(rmm), 16'(ra), 16'(rb)});
      load_t($urandom_range(1, 7), $urandom_range(0, 2));
      for (int it = 0; it < 14; it++) begin
         if ($urandom_range(0, 2) == 0) load_t($urandom_range(1, 7), $urandom_range(0, 3));
         else calc_run($urandom_range(0, 3), $urandom_range(1, 8));
      end
      chk("rnd_err", o_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
